// File: rtl/gpr_dump_reader.sv
// GPR dump reader: walks every register through one read port, streams {index, value}
// records and a closing XOR-checksum record, and flags registers rewritten after capture.
module gpr_dump_reader #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic          WrClk,
    input  logic          rst,
    input  logic          start,
    input  logic          skip_zero,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] Ra,
    input  logic [DW-1:0] busA,
    input  logic          snoop_wr,
    input  logic [AW-1:0] snoop_rw,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_idx,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          dirty,
    output logic [1:0]    dbgState
);

    typedef enum logic [1:0] {IDLE, READ, SEND, SUM} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    state_t        state, stateNext;
    logic [AW-1:0] idx;
    logic [DW-1:0] checksum;
    logic          mode;
    logic          handshake;
    logic          skipRec;
    logic          atLast;
    logic          dirtyHit;

    // Handshake: a record transfers on every rising edge where out_valid && out_ready;
    // once out_valid rises, out_idx/out_data/out_last stay frozen until that transfer.
    assign busy     = (state != IDLE);
    assign Ra       = (state == READ) ? idx : '0;
    assign dbgState = state;

    always_comb begin
        stateNext = state;
        handshake = out_valid & out_ready;
        skipRec   = mode && (busA == '0);
        atLast    = (idx == LAST_IDX);
        // Captured values are pre-write, so a write landing on the capture edge still counts.
        dirtyHit  = snoop_wr && (snoop_rw != '0) &&
                    ((((state == READ) || (state == SEND)) && (snoop_rw <= idx)) ||
                     (state == SUM));
        case (state)
            IDLE: if (start) stateNext = READ;
            READ: begin
                if (skipRec) stateNext = atLast ? SUM : READ;
                else         stateNext = SEND;
            end
            SEND: if (handshake) stateNext = atLast ? SUM : READ;
            SUM:  if (handshake) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge WrClk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            checksum  <= '0;
            mode      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            dirty     <= 1'b0;
        end else begin
            state <= stateNext;
            done  <= 1'b0;
            if (dirtyHit) dirty <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        checksum <= '0;
                        dirty    <= 1'b0;
                        mode     <= skip_zero;
                    end
                end
                READ: begin
                    if (skipRec) begin
                        // A skipped final register goes straight to the checksum record.
                        if (atLast) begin
                            out_data  <= checksum;
                            out_idx   <= '0;
                            out_last  <= 1'b1;
                            out_valid <= 1'b1;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end else begin
                        out_data  <= busA;
                        out_idx   <= idx;
                        checksum  <= checksum ^ busA;
                        out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        if (atLast) begin
                            out_data <= checksum;
                            out_idx  <= '0;
                            out_last <= 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                            idx       <= idx + AW'(1);
                        end
                    end
                end
                SUM: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
